// File: rtl/score_keeper.sv
// Pong match controller: point counting, post-point serve hold,
// winner detection and winner-digit blinking for the score displays.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int HOLD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       start,
  input  logic       frame_tick,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       visible_left,
  output logic       visible_right,
  output logic       freeze,
  output logic       serve,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] WIN_N   = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD_N  = 8'(HOLD_FRAMES);
  localparam logic [7:0] BLINK_N = 8'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_PLAY,
    S_OVER
  } state_t;

  state_t     state_q, state_d;
  logic       pl_q, pl_d;
  logic       pr_q, pr_d;
  logic       st_q, st_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] blink_q, blink_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       vis_l_q, vis_l_d;
  logic       vis_r_q, vis_r_d;
  logic       freeze_q, freeze_d;
  logic       serve_q, serve_d;
  logic       over_q, over_d;
  logic       winner_q, winner_d;

  logic       pl_e, pr_e, st_e;
  logic [3:0] new_score;

  assign pl_e = point_left & ~pl_q;
  assign pr_e = point_right & ~pr_q;
  assign st_e = start & ~st_q;
  assign new_score = pl_e ? score_l_q + 4'd1
                          : score_r_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    pl_d      = point_left;
    pr_d      = point_right;
    st_d      = start;
    hold_d    = hold_q;
    blink_d   = blink_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    vis_l_d   = vis_l_q;
    vis_r_d   = vis_r_q;
    freeze_d  = freeze_q;
    serve_d   = serve_q;
    over_d    = over_q;
    winner_d  = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (st_e) begin
          state_d = S_HOLD;
          hold_d  = 8'd0;
        end
      end
      S_HOLD: begin
        if (frame_tick) begin
          hold_d = hold_q + 8'd1;
          if (hold_q + 8'd1 == HOLD_N) begin
            state_d  = S_PLAY;
            freeze_d = 1'b0;
          end
        end
      end
      S_PLAY: begin
        // simultaneous edges cancel out
        if (pl_e ^ pr_e) begin
          freeze_d = 1'b1;
          serve_d  = pl_e;
          if (pl_e) score_l_d = new_score;
          else      score_r_d = new_score;
          if (new_score == WIN_N) begin
            state_d  = S_OVER;
            over_d   = 1'b1;
            winner_d = pr_e;
            blink_d  = 8'd0;
            vis_l_d  = 1'b1;
            vis_r_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            hold_d  = 8'd0;
          end
        end
      end
      S_OVER: begin
        if (st_e) begin
          state_d   = S_HOLD;
          hold_d    = 8'd0;
          blink_d   = 8'd0;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          vis_l_d   = 1'b1;
          vis_r_d   = 1'b1;
          over_d    = 1'b0;
        end else if (frame_tick) begin
          if (blink_q + 8'd1 == BLINK_N) begin
            blink_d = 8'd0;
            if (winner_q) vis_r_d = ~vis_r_q;
            else          vis_l_d = ~vis_l_q;
          end else begin
            blink_d = blink_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pl_q      <= 1'b0;
      pr_q      <= 1'b0;
      st_q      <= 1'b0;
      hold_q    <= 8'd0;
      blink_q   <= 8'd0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      vis_l_q   <= 1'b1;
      vis_r_q   <= 1'b1;
      freeze_q  <= 1'b1;
      serve_q   <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      st_q      <= st_d;
      hold_q    <= hold_d;
      blink_q   <= blink_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      vis_l_q   <= vis_l_d;
      vis_r_q   <= vis_r_d;
      freeze_q  <= freeze_d;
      serve_q   <= serve_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign score_left    = score_l_q;
  assign score_right   = score_r_q;
  assign visible_left  = vis_l_q;
  assign visible_right = vis_r_q;
  assign freeze        = freeze_q;
  assign serve         = serve_q;
  assign game_over     = over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       point_left, point_right, start, frame_tick;
  logic [3:0] score_left, score_right;
  logic       visible_left, visible_right;
  logic       freeze, serve, game_over, winner;

  score_keeper #(
    .WIN_SCORE(2),
    .HOLD_FRAMES(3),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .point_left(point_left),
    .point_right(point_right),
    .start(start),
    .frame_tick(frame_tick),
    .score_left(score_left),
    .score_right(score_right),
    .visible_left(visible_left),
    .visible_right(visible_right),
    .freeze(freeze),
    .serve(serve),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // {sl, sr, vl, vr, freeze, serve, game_over, winner}
  function automatic logic [13:0] pack(
    input logic [3:0] sl, input logic [3:0] sr,
    input logic vl, input logic vr, input logic fr,
    input logic sv, input logic go, input logic w);
    return {sl, sr, vl, vr, fr, sv, go, w};
  endfunction

  task automatic expect_o(
    input string nm, input logic [3:0] sl, input logic [3:0] sr,
    input logic vl, input logic vr, input logic fr,
    input logic sv, input logic go, input logic w);
    exp_t e;
    e.name = nm;
    e.v = pack(sl, sr, vl, vr, fr, sv, go, w);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [13:0] act, m;
      e = q.pop_front();
      act = pack(score_left, score_right, visible_left, visible_right,
                 freeze, serve, game_over, winner);
      // winner is only meaningful while game_over is set
      m = e.v[1] ? 14'h3fff : 14'h3ffe;
      n_tests++;
      if ((act & m) !== (e.v & m)) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, act, e.v);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    point_left = 1'b0;
    point_right = 1'b0;
    start = 1'b0;
    frame_tick = 1'b0;
    cyc(2);
    expect_o("reset", 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    expect_o("idle", 0, 0, 1, 1, 1, 0, 0, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    expect_o("hold_entry", 0, 0, 1, 1, 1, 0, 0, 0);
    ticks(2);
    expect_o("hold_t2", 0, 0, 1, 1, 1, 0, 0, 0);
    tick();
    expect_o("play", 0, 0, 1, 1, 0, 0, 0, 0);

    point_left = 1'b1;
    cyc(1);
    expect_o("pt_left", 1, 0, 1, 1, 1, 1, 0, 0);
    cyc(9);
    expect_o("pt_held", 1, 0, 1, 1, 1, 1, 0, 0);
    point_left = 1'b0;
    ticks(2);
    expect_o("pt_hold2", 1, 0, 1, 1, 1, 1, 0, 0);
    tick();
    expect_o("play2", 1, 0, 1, 1, 0, 1, 0, 0);

    point_left = 1'b1;
    point_right = 1'b1;
    cyc(1);
    expect_o("simul", 1, 0, 1, 1, 0, 1, 0, 0);
    point_left = 1'b0;
    point_right = 1'b0;
    cyc(1);
    point_right = 1'b1;
    cyc(1);
    expect_o("gap_right", 1, 1, 1, 1, 1, 0, 0, 0);
    point_right = 1'b0;
    ticks(3);
    expect_o("play3", 1, 1, 1, 1, 0, 0, 0, 0);

    point_right = 1'b1;
    cyc(1);
    point_right = 1'b0;
    expect_o("win_right", 1, 2, 1, 1, 1, 0, 1, 1);
    tick();
    expect_o("blink1", 1, 2, 1, 1, 1, 0, 1, 1);
    tick();
    expect_o("blink2", 1, 2, 1, 0, 1, 0, 1, 1);
    tick();
    expect_o("blink3", 1, 2, 1, 0, 1, 0, 1, 1);
    tick();
    expect_o("blink4", 1, 2, 1, 1, 1, 0, 1, 1);
    tick();

    // restart edge with a coincident tick that must not count
    start = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    start = 1'b0;
    frame_tick = 1'b0;
    expect_o("restart", 0, 0, 1, 1, 1, 0, 0, 0);
    ticks(2);
    expect_o("rs_hold2", 0, 0, 1, 1, 1, 0, 0, 0);
    tick();
    expect_o("rs_play", 0, 0, 1, 1, 0, 0, 0, 0);

    point_left = 1'b1;
    cyc(1);
    point_left = 1'b0;
    expect_o("l1", 1, 0, 1, 1, 1, 1, 0, 0);
    ticks(3);
    point_left = 1'b1;
    cyc(1);
    point_left = 1'b0;
    expect_o("win_left", 2, 0, 1, 1, 1, 1, 1, 0);
    ticks(2);
    expect_o("blink_l", 2, 0, 0, 1, 1, 1, 1, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    expect_o("restart2", 0, 0, 1, 1, 1, 1, 0, 0);
    tick();

    reset = 1'b1;
    #1;
    expect_o("async_reset", 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    expect_o("post_reset", 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(2);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Pong match controller that produces the two 4-bit digit values consumed by the on-screen numeric score displays. It counts points reported by the ball/collision logic, freezes play for a short pause after each point, declares a winner at a configurable score and blinks the winner's digit until a restart. It sits between the game-physics logic (point and frame events) and the score-rendering GUI blocks.

## Interface

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1..9.
- HOLD_FRAMES, 60, frame ticks play stays frozen after a point or restart; legal range 1..255.
- BLINK_FRAMES, 30, frame ticks per blink half-period of the winner's digit; legal range 1..255.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- point_left  input  1  level from physics logic; a rising edge scores one point for the left player.
- point_right  input  1  same for the right player.
- start  input  1  player button, synchronous to clk; a rising edge starts or restarts a match.
- frame_tick  input  1  one-cycle pulse per video frame.
- score_left  output  4  left digit value, 0..9.
- score_right  output  4  right digit value, 0..9.
- visible_left  output  1  1 = draw left digit.
- visible_right  output  1  1 = draw right digit.
- freeze  output  1  1 = ball held at the serve position.
- serve  output  1  serving side: 0 = left, 1 = right.
- game_over  output  1  1 while a winner is declared.
- winner  output  1  0 = left, 1 = right; valid only while game_over = 1.

## Operation

- Rising edges on point_left, point_right and start are detected against a registered copy of each input. The registered copies reset to 0.
- State machine:
  - IDLE: freeze = 1. A start edge moves to HOLD with the hold counter cleared.
  - HOLD: freeze = 1. Each frame_tick increments the hold counter. On the tick that makes the count equal HOLD_FRAMES, the block moves to PLAY. Point and start edges are ignored.
  - PLAY: freeze = 0.
    - A single point edge increments that side's score.
    - The scoring side's opponent becomes the server: a left point sets serve = 1, a right point sets serve = 0.
    - If the new score equals WIN_SCORE, the block moves to OVER and sets winner to the scoring side. Otherwise it moves to HOLD with the hold counter cleared.
    - Both point edges in the same cycle: no score change, state stays PLAY.
    - Start edges are ignored.
  - OVER: game_over = 1 and freeze = 1.
    - The loser's digit has visible = 1.
    - The winner's digit visibility toggles after every BLINK_FRAMES frame_ticks, starting at 1.
    - A start edge clears both scores and the blink counter, sets both visible outputs to 1, clears game_over, keeps serve unchanged and moves to HOLD.
- Outside OVER, both visible outputs are 1.
- Scores never exceed WIN_SCORE, and no arithmetic wraps.
- Hold and blink counters are 8 bits wide. Each clears whenever its state is entered.

## Timing

- Reset values, applied asynchronously:
  - state IDLE.
  - score_left = score_right = 0.
  - visible_left = visible_right = 1.
  - freeze = 1, serve = 0, game_over = 0, winner = 0.
  - All counters and edge registers 0.
- Point latency:
  - The input is first sampled high at clock edge N, and score, serve and state update at that same edge N.
  - The outputs are all registered, so the new values are visible during cycle N+1.
  - freeze rises at edge N.
- Hold: freeze falls at the clock edge that samples the HOLD_FRAMES-th frame_tick after HOLD was entered.
- A level held high scores exactly once. The next point requires the input to fall and rise again, and a 1-cycle low gap is sufficient.
- A frame_tick coincident with a state change counts toward the new state's counter only if that state was already active before the edge. Ticks on the entry edge are not counted.
- Reset asserted mid-match, including in HOLD or OVER: all outputs go to their reset values immediately. Operation resumes in IDLE after reset deasserts.

## Test plan

- Reset and start: assert reset, then release. Check score 0/0, freeze = 1, serve = 0. Apply a start pulse and HOLD_FRAMES = 3 frame_ticks. freeze must fall on the 3rd tick edge.
- Point and hold: in PLAY, hold point_left high for 10 cycles. Required result: score_left = 1 one cycle later, and only once; serve = 1; freeze = 1 until 3 more frame_ticks.
- Simultaneous points: in PLAY, raise point_left and point_right in the same cycle. Required result: scores unchanged, freeze stays 0.
- Win and blink, with WIN_SCORE = 2 and BLINK_FRAMES = 2: score right twice. Required result: game_over = 1, winner = 1, visible_left = 1. visible_right follows the sequence 1,1,0,0,1, one value per frame_tick.
- Restart: in OVER, pulse start. Required result: scores 0/0, game_over = 0, both visible = 1, serve unchanged, state HOLD.
- Asynchronous reset in HOLD between clock edges: all outputs take their reset values before the next clk edge.
